// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Module : program_loader_if
// Purpose: Bundles the byte-stream input, the restart request and the
//          program-memory / core-control outputs of program_loader.
// Ports  : master - the environment (UART RX, memory, core) side
//          slave  - the loader side
//          rx_valid/rx_data : one-cycle byte strobe and byte
//          restart          : synchronous reload request
//          pm_we/pm_addr/pm_wdata : program memory write port
//          core_run/loading/error/words_loaded : status
// Rev    : 1.0 - initial release
// ============================================================================
interface program_loader_if #(
  parameter int ADDR_WIDTH = 10
) ();

  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  restart;
  logic                  pm_we;
  logic [ADDR_WIDTH-1:0] pm_addr;
  logic [31:0]           pm_wdata;
  logic                  core_run;
  logic                  loading;
  logic                  error;
  logic [ADDR_WIDTH:0]   words_loaded;

  modport master (
    output rx_valid, rx_data, restart,
    input  pm_we, pm_addr, pm_wdata, core_run, loading, error, words_loaded
  );

  modport slave (
    input  rx_valid, rx_data, restart,
    output pm_we, pm_addr, pm_wdata, core_run, loading, error, words_loaded
  );

endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module : program_loader
// Purpose: Boot-time loader. Receives a 4-byte big-endian word count N
//          followed by N big-endian 32-bit words from the UART receiver,
//          writes them to consecutive program memory addresses and then
//          releases the core. Oversized counts and inter-byte timeouts
//          park the block in an error state until restart or reset.
// Ports  : clk   - system clock, rising edge
//          rst_n - asynchronous active-low reset
//          bus   - program_loader_if.slave (byte stream in, restart in,
//                  program memory write port and status out)
// Rev    : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORDS      = 1024,
  parameter int TIMEOUT    = 1000000
) (
  input logic             clk,
  input logic             rst_n,
  program_loader_if.slave bus
);

  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_LEN   = 2'd0,
    ST_DATA  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           shift_q, shift_d;      // previous three bytes of the current field
  logic [CNT_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      word_idx_q, word_idx_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic                  pm_we_q, pm_we_d;
  logic [ADDR_WIDTH-1:0] pm_addr_q, pm_addr_d;
  logic [31:0]           pm_wdata_q, pm_wdata_d;
  logic                  core_run_q, core_run_d;
  logic                  loading_q, loading_d;
  logic                  error_q, error_d;

  // Full field including the byte being strobed this cycle.
  logic [31:0] w_word;
  logic        w_idle_counting;

  assign w_word          = {shift_q, bus.rx_data};
  // The idle timer only runs once a load is actually in progress.
  assign w_idle_counting = (state_q == ST_DATA) ||
                           ((state_q == ST_LEN) && (byte_cnt_q != 2'd0));

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    idle_d     = idle_q;
    pm_we_d    = 1'b0;
    pm_addr_d  = pm_addr_q;
    pm_wdata_d = pm_wdata_q;

    if (bus.restart) begin
      // Restart takes priority over any byte strobed in the same cycle.
      state_d    = ST_LEN;
      byte_cnt_d = 2'd0;
      word_idx_d = '0;
      idle_d     = '0;
    end else begin
      case (state_q)
        ST_LEN, ST_DATA: begin
          if (bus.rx_valid) begin
            idle_d     = '0;
            byte_cnt_d = byte_cnt_q + 2'd1;   // wraps to 0 after the 4th byte
            shift_d    = w_word[23:0];
            if (byte_cnt_q == 2'd3) begin
              if (state_q == ST_LEN) begin
                // Full 32-bit compare so huge counts cannot alias small ones.
                if (w_word == 32'd0) begin
                  state_d = ST_RUN;
                end else if (w_word > 32'(WORDS)) begin
                  state_d = ST_ERROR;
                end else begin
                  state_d    = ST_DATA;
                  len_d      = w_word[CNT_W-1:0];
                  word_idx_d = '0;
                end
              end else begin
                pm_we_d    = 1'b1;
                pm_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                pm_wdata_d = w_word;
                word_idx_d = word_idx_q + CNT_W'(1);
                if ((word_idx_q + CNT_W'(1)) == len_q) begin
                  state_d = ST_RUN;
                end
              end
            end
          end else if (w_idle_counting) begin
            idle_d = idle_q + IDLE_W'(1);
            if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
              state_d = ST_ERROR;   // any partial word is simply abandoned
            end
          end
        end
        default: begin
          // RUN and ERROR ignore the byte stream.
        end
      endcase
    end

    loading_d  = (state_d == ST_LEN) || (state_d == ST_DATA);
    error_d    = (state_d == ST_ERROR);
    // Coming out of DATA the last write is in flight; hold the core one
    // extra cycle so its first fetch sees the final word in memory.
    core_run_d = (state_d == ST_RUN) && (state_q != ST_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LEN;
      byte_cnt_q <= 2'd0;
      shift_q    <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      idle_q     <= '0;
      pm_we_q    <= 1'b0;
      pm_addr_q  <= '0;
      pm_wdata_q <= '0;
      core_run_q <= 1'b0;
      loading_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      idle_q     <= idle_d;
      pm_we_q    <= pm_we_d;
      pm_addr_q  <= pm_addr_d;
      pm_wdata_q <= pm_wdata_d;
      core_run_q <= core_run_d;
      loading_q  <= loading_d;
      error_q    <= error_d;
    end
  end

  // word_idx only advances on a write, so it doubles as the loaded count.
  assign bus.pm_we        = pm_we_q;
  assign bus.pm_addr      = pm_addr_q;
  assign bus.pm_wdata     = pm_wdata_q;
  assign bus.core_run     = core_run_q;
  assign bus.loading      = loading_q;
  assign bus.error        = error_q;
  assign bus.words_loaded = word_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_program_loader
// Purpose: Self-checking bench for program_loader. Two instances run side
//          by side on the same byte stream (WORDS=1024 and WORDS=4, both
//          with TIMEOUT=16); a byte-list reference model predicts every
//          cycle's outputs, and directed table/hand sequences check the
//          boundary behaviour against fixed values.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  localparam int TMO     = 16;
  localparam int AW_A    = 10;
  localparam int WORDS_A = 1024;
  localparam int AW_B    = 2;
  localparam int WORDS_B = 4;
  localparam int M_LOAD  = 0;
  localparam int M_RUN   = 1;
  localparam int M_ERR   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic       restart = 1'b0;
  logic [7:0] rx_data = 8'h00;

  int checks = 0;
  int failures = 0;

  program_loader_if #(.ADDR_WIDTH(AW_A)) if_a ();
  program_loader_if #(.ADDR_WIDTH(AW_B)) if_b ();

  assign if_a.rx_valid = rx_valid;
  assign if_a.rx_data  = rx_data;
  assign if_a.restart  = restart;
  assign if_b.rx_valid = rx_valid;
  assign if_b.rx_data  = rx_data;
  assign if_b.restart  = restart;

  program_loader #(.ADDR_WIDTH(AW_A), .WORDS(WORDS_A), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  program_loader #(.ADDR_WIDTH(AW_B), .WORDS(WORDS_B), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        run;
    logic        err;
    logic        load;
    logic [31:0] wl;
  } obs_t;

  // ---------------- reference model: list of accepted bytes ----------------
  obs_t        expv [2];
  int          mode [2];
  int          idle_c [2];
  int          bcnt [2];
  logic [7:0]  bq [2][64];
  logic [31:0] nlen [2];
  logic [63:0] log_a [$];
  logic [63:0] log_b [$];

  function automatic void model_reset(int d);
    mode[d]   = M_LOAD;
    idle_c[d] = 0;
    bcnt[d]   = 0;
    nlen[d]   = 32'd0;
    expv[d]   = '0;
  endfunction

  function automatic void model_step(int d, int cap);
    int k;
    expv[d].we = 1'b0;
    if (restart) begin
      mode[d] = M_LOAD; idle_c[d] = 0; bcnt[d] = 0;
      expv[d].wl = 32'd0; expv[d].run = 1'b0;
    end else if (mode[d] == M_LOAD) begin
      if (rx_valid) begin
        if (bcnt[d] < 64) bq[d][bcnt[d]] = rx_data;
        bcnt[d]++;
        idle_c[d] = 0;
        if (bcnt[d] == 4) begin
          nlen[d] = {bq[d][0], bq[d][1], bq[d][2], bq[d][3]};
          if (nlen[d] == 32'd0) begin
            mode[d] = M_RUN; expv[d].run = 1'b1;
          end else if (nlen[d] > 32'(cap)) begin
            mode[d] = M_ERR;
          end
        end else if (bcnt[d] > 4 && (bcnt[d] % 4) == 0) begin
          k = bcnt[d] / 4 - 2;
          expv[d].we   = 1'b1;
          expv[d].addr = 32'(k);
          expv[d].data = {bq[d][bcnt[d]-4], bq[d][bcnt[d]-3], bq[d][bcnt[d]-2], bq[d][bcnt[d]-1]};
          expv[d].wl   = 32'(k + 1);
          if (32'(k + 1) == nlen[d]) mode[d] = M_RUN;  // core released a cycle later
        end
      end else if (bcnt[d] > 0) begin
        idle_c[d]++;
        if (idle_c[d] >= TMO) mode[d] = M_ERR;
      end
    end else if (mode[d] == M_RUN) begin
      expv[d].run = 1'b1;
    end
    expv[d].err  = (mode[d] == M_ERR);
    expv[d].load = (mode[d] == M_LOAD);
  endfunction

  function automatic obs_t observe(int d);
    obs_t o;
    if (d == 0) begin
      o.we = if_a.pm_we; o.addr = 32'(if_a.pm_addr); o.data = if_a.pm_wdata;
      o.run = if_a.core_run; o.err = if_a.error; o.load = if_a.loading;
      o.wl = 32'(if_a.words_loaded);
    end else begin
      o.we = if_b.pm_we; o.addr = 32'(if_b.pm_addr); o.data = if_b.pm_wdata;
      o.run = if_b.core_run; o.err = if_b.error; o.load = if_b.loading;
      o.wl = 32'(if_b.words_loaded);
    end
    return o;
  endfunction

  function automatic void check_obs(int d);
    obs_t a;
    obs_t e;
    logic bad;
    a = observe(d);
    e = expv[d];
    bad = (a.we !== e.we) || (a.run !== e.run) || (a.err !== e.err) ||
          (a.load !== e.load) || (a.wl !== e.wl) ||
          (e.we && ((a.addr !== e.addr) || (a.data !== e.data)));
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL cycle_dut%0d t=%0t actual we=%b addr=%0d data=%h run=%b err=%b load=%b wl=%0d required we=%b addr=%0d data=%h run=%b err=%b load=%b wl=%0d",
               d, $time, a.we, a.addr, a.data, a.run, a.err, a.load, a.wl,
               e.we, e.addr, e.data, e.run, e.err, e.load, e.wl);
    end
  endfunction

  // Compare last cycle's outputs, then predict the next cycle from the
  // inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) model_reset(d);
      check_obs(d);
      if (rst_n) model_step(d, (d == 0) ? WORDS_A : WORDS_B);
    end
    if (if_a.pm_we === 1'b1) log_a.push_back({32'(if_a.pm_addr), if_a.pm_wdata});
    if (if_b.pm_we === 1'b1) log_b.push_back({32'(if_b.pm_addr), if_b.pm_wdata});
  end

  // ---------------- helpers ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_log(string name, int d, int idx, logic [31:0] addr, logic [31:0] data);
    logic [63:0] ent;
    int sz;
    sz = (d == 0) ? log_a.size() : log_b.size();
    checks++;
    if (idx >= sz) begin
      failures++;
      $display("FAIL %s actual=missing_write required=%h:%h", name, addr, data);
    end else begin
      ent = (d == 0) ? log_a[idx] : log_b[idx];
      if (ent !== {addr, data}) begin
        failures++;
        $display("FAIL %s actual=%h:%h required=%h:%h", name, ent[63:32], ent[31:0], addr, data);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [7:0] d, logic r);
    rx_valid = v; rx_data = d; restart = r;
    tick();
    rx_valid = 1'b0; restart = 1'b0;
  endtask

  task automatic send_word(logic [31:0] w);
    for (int i = 3; i >= 0; i--) drive(1'b1, w[i*8 +: 8], 1'b0);
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic do_restart();
    drive(1'b0, 8'h00, 1'b1);
    log_a.delete();
    log_b.delete();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] n;
    int          words;
    logic        err_a;
    logic        run_a;
    int          wr_a;
    logic        err_b;
    logic        run_b;
    int          wr_b;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] n;
    logic [31:0] w;
    int nw;
    int gap;

    vecs[0] = '{32'd0,          0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 0};
    vecs[1] = '{32'd1025,       0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0};
    vecs[2] = '{32'h8000_0001,  0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0};
    vecs[3] = '{32'd2,          2, 1'b0, 1'b1, 2, 1'b0, 1'b1, 2};
    vecs[4] = '{32'd5,          5, 1'b0, 1'b1, 5, 1'b1, 1'b0, 0};
    vecs[5] = '{32'd4,          5, 1'b0, 1'b1, 4, 1'b0, 1'b1, 4};
    vecs[6] = '{32'd1024,       0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0};
    vecs[7] = '{32'd3,          2, 1'b1, 1'b0, 2, 1'b1, 1'b0, 2};
    vecs[8] = '{32'd1,          1, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1};

    idle(3);
    rst_n = 1'b1;
    tick();
    chk("reset_loading_after_release", 32'(if_a.loading), 32'd1);
    chk("reset_words_loaded", 32'(if_a.words_loaded), 32'd0);

    // Basic load: two words, back-to-back bytes.
    send_word(32'd2);
    send_word(32'h2408_0005);
    chk("basic_w0_we", 32'(if_a.pm_we), 32'd1);
    chk("basic_w0_addr", 32'(if_a.pm_addr), 32'd0);
    chk("basic_w0_data", if_a.pm_wdata, 32'h2408_0005);
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'h0C, 1'b0);
    chk("basic_w1_we", 32'(if_a.pm_we), 32'd1);
    chk("basic_w1_addr", 32'(if_a.pm_addr), 32'd1);
    chk("basic_run_not_yet", 32'(if_a.core_run), 32'd0);
    tick();
    chk("basic_we_drop", 32'(if_a.pm_we), 32'd0);
    chk("basic_run", 32'(if_a.core_run), 32'd1);
    chk("basic_words_loaded", 32'(if_a.words_loaded), 32'd2);
    chk_log("basic_log0", 0, 0, 32'd0, 32'h2408_0005);
    chk_log("basic_log1", 0, 1, 32'd1, 32'h0000_000C);

    // Asynchronous reset asserted mid-cycle.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("areset_we", 32'(if_a.pm_we), 32'd0);
    chk("areset_run", 32'(if_a.core_run), 32'd0);
    chk("areset_err", 32'(if_a.error), 32'd0);
    chk("areset_wl", 32'(if_a.words_loaded), 32'd0);
    chk("areset_loading", 32'(if_a.loading), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("areset_release_loading", 32'(if_a.loading), 32'd1);

    // Empty and oversize counts: exact one-cycle response.
    do_restart();
    send_word(32'd0);
    chk("empty_run_t1", 32'(if_a.core_run), 32'd1);
    do_restart();
    send_word(32'd1025);
    chk("over_err_t1", 32'(if_a.error), 32'd1);
    chk("over_loading_t1", 32'(if_a.loading), 32'd0);

    // Timeout: N=1 and two data bytes, then silence.
    do_restart();
    send_word(32'd1);
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    idle(TMO - 1);
    chk("timeout_err_early", 32'(if_a.error), 32'd0);
    idle(1);
    chk("timeout_err", 32'(if_a.error), 32'd1);
    chk("timeout_no_write", 32'(log_a.size()), 32'd0);
    do_restart();
    chk("timeout_restart_loading", 32'(if_a.loading), 32'd1);
    chk("timeout_restart_err", 32'(if_a.error), 32'd0);

    // Restart mid-load, colliding with a byte that must be dropped.
    do_restart();
    send_word(32'd3);
    send_word(32'h0102_0304);
    drive(1'b1, 8'hAA, 1'b1);
    chk("rst_mid_loading", 32'(if_a.loading), 32'd1);
    chk("rst_mid_wl", 32'(if_a.words_loaded), 32'd0);
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    idle(2);
    chk_log("rst_mid_first", 0, 0, 32'd0, 32'h0102_0304);
    chk_log("rst_mid_reload", 0, 1, 32'd0, 32'hDEAD_BEEF);
    chk("rst_mid_run", 32'(if_a.core_run), 32'd1);

    // Capacity on the 4-word instance, plus a trailing extra word.
    do_restart();
    send_word(32'd4);
    for (int i = 0; i < 4; i++) send_word(32'hC0DE_0000 + 32'(i));
    send_word(32'h5555_AAAA);
    idle(3);
    for (int i = 0; i < 4; i++) chk_log("cap_write", 1, i, 32'(i), 32'hC0DE_0000 + 32'(i));
    chk("cap_no_fifth", 32'(log_b.size()), 32'd4);
    chk("cap_run", 32'(if_b.core_run), 32'd1);
    chk("cap_no_err", 32'(if_b.error), 32'd0);

    // Table-driven loads, each followed by enough idle to settle.
    for (int v = 0; v < 9; v++) begin
      do_restart();
      send_word(vecs[v].n);
      for (int i = 0; i < vecs[v].words; i++) send_word($urandom);
      idle(TMO + 4);
      chk("tbl_err_a", 32'(if_a.error), 32'(vecs[v].err_a));
      chk("tbl_run_a", 32'(if_a.core_run), 32'(vecs[v].run_a));
      chk("tbl_writes_a", 32'(log_a.size()), 32'(vecs[v].wr_a));
      chk("tbl_wl_a", 32'(if_a.words_loaded), 32'(vecs[v].wr_a));
      chk("tbl_err_b", 32'(if_b.error), 32'(vecs[v].err_b));
      chk("tbl_run_b", 32'(if_b.core_run), 32'(vecs[v].run_b));
      chk("tbl_writes_b", 32'(log_b.size()), 32'(vecs[v].wr_b));
    end

    // Randomized loads: gaps, occasional timeouts and colliding restarts.
    for (int r = 0; r < 40; r++) begin
      do_restart();
      n = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0001_0000) : 32'($urandom_range(0, 6));
      nw = (n > 32'd6) ? 1 : int'(n) + $urandom_range(0, 1);
      for (int i = 3; i >= 0; i--) begin
        idle($urandom_range(0, 2));
        drive(1'b1, n[i*8 +: 8], 1'b0);
      end
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        for (int i = 3; i >= 0; i--) begin
          gap = ($urandom_range(0, 59) == 0) ? TMO + 2 : $urandom_range(0, 2);
          idle(gap);
          drive(1'b1, w[i*8 +: 8], ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0);
        end
      end
      idle($urandom_range(1, TMO + 3));
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
